fpu_issue_ctrl: RTL and testbench

Sequencing and sharing controller for the team's single-cycle combinational FPU datapath. It arbitrates two requesters round-robin and resolves dynamic rounding mode from an internal frm register. It drives the FPU's ftype/roundingMode/operand-select controls, holds fused multiply-add ops for a configurable multicycle window, and registers results behind a valid/ready response port. It also owns the fcsr state (frm, accrued fflags).

---
 rtl/fpu_issue_ctrl_if.sv | 44 ++++
 rtl/fpu_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_ctrl_if.sv
// Bundle of the requester, datapath, response and fcsr signals of the FPU issue controller.
// No logic of its own: all timing belongs to the controller.
// Backpressure is carried by req_ready (per requester) and resp_ready (response port).
interface fpu_issue_ctrl_if #(
    parameter int XLEN = 64,
    parameter int FLEN = 32
);
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [9:0]      req_ftype;
    logic [5:0]      req_rm;
    logic            fpu_sel;
    logic [4:0]      fpu_ftype;
    logic [2:0]      fpu_rm;
    logic [FLEN-1:0] fpu_res_f;
    logic [XLEN-1:0] fpu_res_x;
    logic [4:0]      fpu_flags;
    logic            resp_valid;
    logic            resp_ready;
    logic            resp_id;
    logic [FLEN-1:0] resp_f;
    logic [XLEN-1:0] resp_x;
    logic [4:0]      resp_flags;
    logic            resp_illegal;
    logic            csr_we;
    logic [7:0]      csr_wdata;
    logic [7:0]      csr_rdata;

    // Requester / datapath / CSR side
    modport master (
        output req_valid, req_ftype, req_rm, fpu_res_f, fpu_res_x, fpu_flags,
               resp_ready, csr_we, csr_wdata,
        input  req_ready, fpu_sel, fpu_ftype, fpu_rm, resp_valid, resp_id,
               resp_f, resp_x, resp_flags, resp_illegal, csr_rdata
    );

    // Controller side
    modport slave (
        input  req_valid, req_ftype, req_rm, fpu_res_f, fpu_res_x, fpu_flags,
               resp_ready, csr_we, csr_wdata,
        output req_ready, fpu_sel, fpu_ftype, fpu_rm, resp_valid, resp_id,
               resp_f, resp_x, resp_flags, resp_illegal, csr_rdata
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Round-robin issue of two requesters onto a shared combinational FPU, with frm/fflags ownership.
// Latency: 1 cycle for plain and illegal ops, FMA_LAT cycles for fused multiply-add (ftype 5..8).
// Backpressure: no grant while BUSY or while a held response is not being drained by resp_ready.
module fpu_issue_ctrl #(
    parameter int XLEN      = 64,
    parameter int FLEN      = 32,
    parameter int FMA_LAT   = 2,
    parameter int MAX_FTYPE = 20
) (
    input  logic           clk,
    input  logic           rst,
    fpu_issue_ctrl_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [4:0] MAX_FT   = 5'(MAX_FTYPE);
    localparam logic [3:0] CNT_INIT = 4'(FMA_LAT - 1);
    localparam bit         MULTI    = (FMA_LAT > 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            last_grant_q, last_grant_d;
    logic [2:0]      frm_q, frm_d;
    logic [4:0]      fflags_q, fflags_d;
    logic            sel_q, sel_d;
    logic [4:0]      ftype_q, ftype_d;
    logic [2:0]      rm_q, rm_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_id_q, resp_id_d;
    logic [FLEN-1:0] resp_f_q, resp_f_d;
    logic [XLEN-1:0] resp_x_q, resp_x_d;
    logic [4:0]      resp_flags_q, resp_flags_d;
    logic            resp_illegal_q, resp_illegal_d;

    logic            slot_free, grant_vld, grant_idx;
    logic [4:0]      g_ftype;
    logic [2:0]      g_rm, eff_rm;
    logic            g_illegal, g_fma;
    logic            cap_vld, cap_illegal, cap_legal, cap_id;
    logic [4:0]      acc_flags;

    // Pick a requester and decode its op; dynamic rm resolves against the live frm register
    always_comb begin
        slot_free = !resp_valid_q || bus.resp_ready;
        grant_vld = (state_q == IDLE) && slot_free && (bus.req_valid != 2'b00);
        // Lone requester wins; on contention the one not granted last time wins
        grant_idx = bus.req_valid[1] & (~bus.req_valid[0] | ~last_grant_q);
        g_ftype   = grant_idx ? bus.req_ftype[9:5] : bus.req_ftype[4:0];
        g_rm      = grant_idx ? bus.req_rm[5:3]    : bus.req_rm[2:0];
        eff_rm    = (g_rm == 3'd7) ? frm_q : g_rm;
        g_illegal = (eff_rm >= 3'd5) || (g_ftype > MAX_FT);
        g_fma     = (g_ftype >= 5'd5) && (g_ftype <= 5'd8);
    end

    assign bus.req_ready = grant_vld ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign bus.fpu_sel   = grant_vld ? grant_idx : sel_q;
    assign bus.fpu_ftype = grant_vld ? g_ftype   : ftype_q;
    assign bus.fpu_rm    = grant_vld ? eff_rm    : rm_q;

    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_f       = resp_f_q;
    assign bus.resp_x       = resp_x_q;
    assign bus.resp_flags   = resp_flags_q;
    assign bus.resp_illegal = resp_illegal_q;
    assign bus.csr_rdata    = {frm_q, fflags_q};

    // Sequencing, response capture and fcsr update
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        sel_d          = sel_q;
        ftype_d        = ftype_q;
        rm_d           = rm_q;
        cap_vld        = 1'b0;
        cap_illegal    = 1'b0;
        cap_id         = sel_q;

        if (state_q == BUSY) begin
            // Datapath is driven from the latched copies; result is taken on the last busy edge
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                cap_vld = 1'b1;
                state_d = IDLE;
            end
        end else if (grant_vld) begin
            last_grant_d = grant_idx;
            sel_d        = grant_idx;
            ftype_d      = g_ftype;
            rm_d         = eff_rm;
            cap_id       = grant_idx;
            if (g_illegal) begin
                cap_vld     = 1'b1;
                cap_illegal = 1'b1;
            end else if (g_fma && MULTI) begin
                state_d = BUSY;
                cnt_d   = CNT_INIT;
            end else begin
                cap_vld = 1'b1;
            end
        end
        cap_legal = cap_vld && !cap_illegal;

        // Response register: a new capture wins over the handshake clear
        resp_valid_d   = resp_valid_q && !bus.resp_ready;
        resp_id_d      = resp_id_q;
        resp_f_d       = resp_f_q;
        resp_x_d       = resp_x_q;
        resp_flags_d   = resp_flags_q;
        resp_illegal_d = resp_illegal_q;
        if (cap_vld) begin
            resp_valid_d   = 1'b1;
            resp_id_d      = cap_id;
            resp_illegal_d = cap_illegal;
            resp_f_d       = cap_illegal ? '0 : bus.fpu_res_f;
            resp_x_d       = cap_illegal ? '0 : bus.fpu_res_x;
            resp_flags_d   = cap_illegal ? '0 : bus.fpu_flags;
        end

        // Flags raised in the same cycle as a CSR write still accrue on top of it
        acc_flags = cap_legal ? bus.fpu_flags : 5'd0;
        frm_d     = frm_q;
        fflags_d  = fflags_q | acc_flags;
        if (bus.csr_we) begin
            frm_d    = bus.csr_wdata[7:5];
            fflags_d = bus.csr_wdata[4:0] | acc_flags;
        end
    end

    // State registers; reset drops any in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            last_grant_q   <= 1'b1;
            frm_q          <= 3'd0;
            fflags_q       <= 5'd0;
            sel_q          <= 1'b0;
            ftype_q        <= 5'd0;
            rm_q           <= 3'd0;
            resp_valid_q   <= 1'b0;
            resp_id_q      <= 1'b0;
            resp_f_q       <= '0;
            resp_x_q       <= '0;
            resp_flags_q   <= 5'd0;
            resp_illegal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            frm_q          <= frm_d;
            fflags_q       <= fflags_d;
            sel_q          <= sel_d;
            ftype_q        <= ftype_d;
            rm_q           <= rm_d;
            resp_valid_q   <= resp_valid_d;
            resp_id_q      <= resp_id_d;
            resp_f_q       <= resp_f_d;
            resp_x_q       <= resp_x_d;
            resp_flags_q   <= resp_flags_d;
            resp_illegal_q <= resp_illegal_d;
        end
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios plus a randomized run against a transaction model.
// Model tracks grants, FMA completion cycle, response slot and fcsr using plain variables.
// Inputs change 1 time unit after posedge; combinational outputs sampled at negedge.
module tb_fpu_issue_ctrl;
    localparam int XLEN = 64;
    localparam int FLEN = 32;
    localparam int LAT  = 3;
    localparam int MAXF = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_issue_ctrl_if #(.XLEN(XLEN), .FLEN(FLEN)) bus ();
    fpu_issue_ctrl #(.XLEN(XLEN), .FLEN(FLEN), .FMA_LAT(LAT), .MAX_FTYPE(MAXF))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model state
    int              cyc;
    bit              m_pend;
    int              m_due;
    int              m_last;
    bit              m_lvalid;
    logic            m_lsel;
    logic [4:0]      m_lftype;
    logic [2:0]      m_lrm;
    logic [2:0]      m_frm;
    logic [4:0]      m_fflags;
    logic            m_rv, m_rid, m_rill;
    logic [FLEN-1:0] m_rf;
    logic [XLEN-1:0] m_rx;
    logic [4:0]      m_rflags;

    // Per-cycle prediction and observed combinational outputs
    int         e_gnt;
    logic [1:0] e_ready;
    logic       e_sel, e_ill, e_fma;
    logic [4:0] e_ftype;
    logic [2:0] e_rm;
    logic [1:0] o_ready;
    logic       o_sel;
    logic [4:0] o_ftype;
    logic [2:0] o_rm;

    task automatic model_reset();
        cyc = 0; m_pend = 0; m_due = 0; m_last = 1; m_lvalid = 0;
        m_lsel = 0; m_lftype = 0; m_lrm = 0; m_frm = 0; m_fflags = 0;
        m_rv = 0; m_rid = 0; m_rill = 0; m_rf = '0; m_rx = '0; m_rflags = 0;
    endtask

    task automatic predict();
        logic       free;
        logic [4:0] ft;
        logic [2:0] rm;
        free  = !m_rv || bus.resp_ready;
        e_gnt = -1;
        if (!m_pend && free) begin
            if (bus.req_valid == 2'b11)      e_gnt = 1 - m_last;
            else if (bus.req_valid == 2'b01) e_gnt = 0;
            else if (bus.req_valid == 2'b10) e_gnt = 1;
        end
        e_ready = 2'b00;
        e_ill   = 1'b0;
        e_fma   = 1'b0;
        if (e_gnt >= 0) begin
            e_ready[e_gnt] = 1'b1;
            ft      = (e_gnt == 1) ? bus.req_ftype[9:5] : bus.req_ftype[4:0];
            rm      = (e_gnt == 1) ? bus.req_rm[5:3]    : bus.req_rm[2:0];
            e_sel   = (e_gnt == 1);
            e_ftype = ft;
            e_rm    = (rm == 3'd7) ? m_frm : rm;
            e_ill   = (e_rm > 3'd4) || (int'(ft) > MAXF);
            e_fma   = (ft >= 5'd5) && (ft <= 5'd8);
        end else begin
            e_sel = m_lsel; e_ftype = m_lftype; e_rm = m_lrm;
        end
    endtask

    task automatic commit();
        logic       cap, cill, cid;
        logic [4:0] acc;
        cyc++;
        cap = 0; cill = 0; cid = 0;
        if (m_pend) begin
            if (cyc == m_due) begin
                m_pend = 0; cap = 1; cid = m_lsel;
            end
        end else if (e_gnt >= 0) begin
            m_last = e_gnt; m_lvalid = 1;
            m_lsel = e_sel; m_lftype = e_ftype; m_lrm = e_rm; cid = e_sel;
            if (e_ill) begin
                cap = 1; cill = 1;
            end else if (e_fma && LAT > 1) begin
                m_pend = 1; m_due = cyc + LAT - 1;
            end else begin
                cap = 1;
            end
        end
        if (cap) begin
            m_rv = 1; m_rid = cid; m_rill = cill;
            m_rf = cill ? '0 : bus.fpu_res_f;
            m_rx = cill ? '0 : bus.fpu_res_x;
            m_rflags = cill ? 5'd0 : bus.fpu_flags;
        end else if (m_rv && bus.resp_ready) begin
            m_rv = 0;
        end
        acc = (cap && !cill) ? bus.fpu_flags : 5'd0;
        if (bus.csr_we) begin
            m_frm = bus.csr_wdata[7:5];
            m_fflags = bus.csr_wdata[4:0] | acc;
        end else begin
            m_fflags = m_fflags | acc;
        end
    endtask

    // One clock: sample combinational outputs, predict, clock, update model
    task automatic tick();
        @(negedge clk);
        o_ready = bus.req_ready; o_sel = bus.fpu_sel; o_ftype = bus.fpu_ftype; o_rm = bus.fpu_rm;
        predict();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", bus.resp_valid); end
        checks++; if (bus.csr_rdata !== 8'h00) begin errors++; $display("FAIL rst_csr got %h exp 00", bus.csr_rdata); end
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", bus.req_ready); end
        checks++; if ({bus.resp_id, bus.resp_illegal, bus.resp_flags} !== 7'd0) begin errors++; $display("FAIL rst_resp_meta got %b exp 0", {bus.resp_id, bus.resp_illegal, bus.resp_flags}); end
        checks++; if ({bus.resp_f, bus.resp_x} !== 96'd0) begin errors++; $display("FAIL rst_resp_data got %h exp 0", {bus.resp_f, bus.resp_x}); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        bus.req_valid = 2'b01; bus.req_ftype = 10'd0; bus.req_rm = 6'd0;
        bus.fpu_flags = 5'b00001; bus.fpu_res_f = $urandom; bus.fpu_res_x = {$urandom, $urandom};
        tick();
        checks++; if (o_ready !== 2'b01) begin errors++; $display("FAIL basic_ready got %b exp 01", o_ready); end
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0) begin errors++; $display("FAIL basic_resp got v%b id%b exp v1 id0", bus.resp_valid, bus.resp_id); end
        checks++; if (bus.resp_flags !== 5'b00001 || bus.resp_f !== m_rf || bus.resp_x !== m_rx) begin errors++; $display("FAIL basic_data got %b %h %h exp 00001 %h %h", bus.resp_flags, bus.resp_f, bus.resp_x, m_rf, m_rx); end
        checks++; if (bus.csr_rdata !== 8'h01) begin errors++; $display("FAIL basic_csr got %h exp 01", bus.csr_rdata); end
        bus.req_valid = 2'b00; tick();
    endtask

    task automatic test_round_robin();
        bus.req_valid = 2'b11; bus.req_ftype = {5'd1, 5'd0}; bus.req_rm = {3'd1, 3'd2}; bus.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.fpu_res_f = $urandom; bus.fpu_res_x = {$urandom, $urandom}; bus.fpu_flags = 5'($urandom);
            tick();
            checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL rr_ready k%0d got %b exp %b", k, o_ready, e_ready); end
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== m_rid || bus.resp_f !== m_rf) begin errors++; $display("FAIL rr_resp k%0d got v%b id%b f%h exp v1 id%b f%h", k, bus.resp_valid, bus.resp_id, bus.resp_f, m_rid, m_rf); end
        end
        bus.req_valid = 2'b00; tick();
    endtask

    task automatic test_dyn_rm();
        bus.csr_we = 1'b1; bus.csr_wdata = {3'd3, 5'b00100}; tick(); bus.csr_we = 1'b0;
        checks++; if (bus.csr_rdata !== {m_frm, m_fflags}) begin errors++; $display("FAIL rm_csr1 got %h exp %h", bus.csr_rdata, {m_frm, m_fflags}); end
        bus.req_valid = 2'b01; bus.req_ftype = {5'd0, 5'd2}; bus.req_rm = {3'd0, 3'd7}; bus.fpu_flags = 5'b00010;
        tick();
        checks++; if (o_rm !== 3'd3 || o_rm !== e_rm) begin errors++; $display("FAIL rm_dyn got %0d exp %0d", o_rm, e_rm); end
        checks++; if (bus.resp_illegal !== 1'b0 || bus.csr_rdata !== {m_frm, m_fflags}) begin errors++; $display("FAIL rm_legal got ill%b csr%h exp ill0 csr%h", bus.resp_illegal, bus.csr_rdata, {m_frm, m_fflags}); end
        bus.req_valid = 2'b00; bus.csr_we = 1'b1; bus.csr_wdata = {3'd5, 5'b00001}; tick(); bus.csr_we = 1'b0;
        bus.req_valid = 2'b01; bus.req_rm = {3'd0, 3'd7}; bus.fpu_flags = 5'b11111; bus.fpu_res_f = $urandom;
        tick();
        checks++; if (bus.resp_illegal !== 1'b1 || bus.resp_flags !== 5'd0 || bus.resp_f !== '0 || bus.resp_x !== '0) begin errors++; $display("FAIL rm_illegal got ill%b fl%b f%h x%h exp ill1 zeros", bus.resp_illegal, bus.resp_flags, bus.resp_f, bus.resp_x); end
        checks++; if (bus.csr_rdata !== 8'hA1) begin errors++; $display("FAIL rm_fflags_kept got %h exp a1", bus.csr_rdata); end
        bus.req_ftype = {5'd0, 5'd21}; bus.req_rm = {3'd0, 3'd0};
        tick();
        checks++; if (bus.resp_illegal !== m_rill || m_rill !== 1'b1) begin errors++; $display("FAIL ftype_illegal got %b exp 1", bus.resp_illegal); end
        bus.req_valid = 2'b00; tick();
    endtask

    task automatic test_fma();
        bus.resp_ready = 1'b1; bus.csr_we = 1'b1; bus.csr_wdata = {3'd2, 5'd0}; tick(); bus.csr_we = 1'b0;
        bus.req_valid = 2'b01; bus.req_ftype = {5'd1, 5'd5}; bus.req_rm = {3'd0, 3'd7};
        tick();
        checks++; if (o_ready !== 2'b01 || o_rm !== 3'd2) begin errors++; $display("FAIL fma_grant got r%b rm%0d exp r01 rm2", o_ready, o_rm); end
        // frm changes mid-op must not disturb the latched rounding mode
        bus.req_valid = 2'b11; bus.csr_we = 1'b1; bus.csr_wdata = {3'd4, 5'd0};
        for (int k = 0; k < LAT - 1; k++) begin
            bus.fpu_res_f = $urandom; bus.fpu_res_x = {$urandom, $urandom}; bus.fpu_flags = 5'($urandom);
            tick(); bus.csr_we = 1'b0;
            checks++; if (o_ready !== 2'b00 || o_ready !== e_ready) begin errors++; $display("FAIL fma_busy_ready k%0d got %b exp 00", k, o_ready); end
            checks++; if (o_ftype !== 5'd5 || o_rm !== e_rm) begin errors++; $display("FAIL fma_held k%0d got ft%0d rm%0d exp ft5 rm%0d", k, o_ftype, o_rm, e_rm); end
            checks++; if (bus.resp_valid !== m_rv) begin errors++; $display("FAIL fma_valid k%0d got %b exp %b", k, bus.resp_valid, m_rv); end
        end
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_f !== m_rf || bus.resp_flags !== m_rflags) begin errors++; $display("FAIL fma_resp got v%b f%h fl%b exp v1 f%h fl%b", bus.resp_valid, bus.resp_f, bus.resp_flags, m_rf, m_rflags); end
        tick();
        checks++; if (o_ready !== 2'b10 || o_ready !== e_ready) begin errors++; $display("FAIL fma_then_req1 got %b exp 10", o_ready); end
        bus.req_valid = 2'b00; tick();
    endtask

    task automatic test_backpressure();
        bus.resp_ready = 1'b0; bus.req_valid = 2'b01; bus.req_ftype = {5'd0, 5'd3}; bus.req_rm = 6'd0;
        bus.fpu_res_f = $urandom; bus.fpu_flags = 5'd0;
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.fpu_res_f = $urandom; bus.fpu_res_x = {$urandom, $urandom};
            tick();
            checks++; if (o_ready !== 2'b00) begin errors++; $display("FAIL bp_ready k%0d got %b exp 00", k, o_ready); end
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_f !== m_rf || bus.resp_x !== m_rx) begin errors++; $display("FAIL bp_hold k%0d got v%b f%h exp v1 f%h", k, bus.resp_valid, bus.resp_f, m_rf); end
        end
        bus.resp_ready = 1'b1; bus.fpu_res_f = $urandom;
        tick();
        checks++; if (o_ready !== 2'b01) begin errors++; $display("FAIL bp_regrant got %b exp 01", o_ready); end
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_f !== m_rf) begin errors++; $display("FAIL bp_newdata got v%b f%h exp v1 f%h", bus.resp_valid, bus.resp_f, m_rf); end
        bus.req_valid = 2'b00; tick();
    endtask

    task automatic test_reset_busy();
        bus.resp_ready = 1'b1; bus.req_valid = 2'b01; bus.req_ftype = {5'd0, 5'd6}; bus.req_rm = 6'd0;
        tick();
        bus.req_valid = 2'b00;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.resp_valid !== 1'b0 || bus.csr_rdata !== 8'h00) begin errors++; $display("FAIL rstbusy_now got v%b csr%h exp v0 csr00", bus.resp_valid, bus.csr_rdata); end
        model_reset();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < LAT + 1; k++) begin
            tick();
            checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rstbusy_drop k%0d got %b exp 0", k, bus.resp_valid); end
        end
        bus.req_valid = 2'b01; bus.req_ftype = {5'd0, 5'd1}; bus.fpu_flags = 5'b10000;
        bus.csr_we = 1'b1; bus.csr_wdata = 8'h00;
        tick(); bus.csr_we = 1'b0; bus.req_valid = 2'b00;
        checks++; if (bus.csr_rdata !== 8'h10) begin errors++; $display("FAIL csr_accrue got %h exp 10", bus.csr_rdata); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.req_valid  = 2'($urandom);
            bus.req_ftype  = {5'($urandom_range(0, 23)), 5'($urandom_range(0, 23))};
            bus.req_rm     = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            bus.fpu_res_f  = $urandom;
            bus.fpu_res_x  = {$urandom, $urandom};
            bus.fpu_flags  = 5'($urandom);
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus.csr_we     = ($urandom_range(0, 15) == 0);
            bus.csr_wdata  = {3'($urandom_range(0, 4)), 5'($urandom)};
            tick();
            checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL rnd_ready i%0d got %b exp %b", i, o_ready, e_ready); end
            if (m_lvalid) begin
                checks++; if ({o_sel, o_ftype, o_rm} !== {e_sel, e_ftype, e_rm}) begin errors++; $display("FAIL rnd_ctrl i%0d got %b exp %b", i, {o_sel, o_ftype, o_rm}, {e_sel, e_ftype, e_rm}); end
            end
            checks++; if (bus.resp_valid !== m_rv) begin errors++; $display("FAIL rnd_valid i%0d got %b exp %b", i, bus.resp_valid, m_rv); end
            if (m_rv) begin
                checks++; if ({bus.resp_id, bus.resp_illegal, bus.resp_flags, bus.resp_f, bus.resp_x} !== {m_rid, m_rill, m_rflags, m_rf, m_rx}) begin errors++; $display("FAIL rnd_resp i%0d got %h exp %h", i, {bus.resp_id, bus.resp_illegal, bus.resp_flags, bus.resp_f, bus.resp_x}, {m_rid, m_rill, m_rflags, m_rf, m_rx}); end
            end
            checks++; if (bus.csr_rdata !== {m_frm, m_fflags}) begin errors++; $display("FAIL rnd_csr i%0d got %h exp %h", i, bus.csr_rdata, {m_frm, m_fflags}); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 2'b00; bus.req_ftype = 10'd0; bus.req_rm = 6'd0;
        bus.fpu_res_f = '0; bus.fpu_res_x = '0; bus.fpu_flags = 5'd0;
        bus.resp_ready = 1'b1; bus.csr_we = 1'b0; bus.csr_wdata = 8'd0;
        model_reset();
        test_reset();
        test_basic();
        test_round_robin();
        test_dyn_rm();
        test_fma();
        test_backpressure();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
